// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit read-side controller:
//     - state_t          : transmit FSM state encoding
//     - UART_DATA_BITS   : payload bits per frame
//     - UART_IDLE_LEVEL  : line level while no frame is being sent
//     - clog2()          : ceiling log2, used to size the baud counter
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period counter for the UART transmitter. Counts 0..DIV-1 while run is
//   high and wraps; tick marks the last clock of a bit period (count DIV-1).
//   pre_tick marks the clock before that, letting the parent register an
//   output that must be high exactly on the last clock of a bit.
//
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset (count -> 0)
//     clr      in   synchronous clear of the count (wins over run)
//     run      in   advance the count this clock
//     tick     out  count == DIV-1
//     pre_tick out  count == DIV-2
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = clog2(DIV);

  logic [CW-1:0] count;

  assign tick     = (count == CW'(DIV - 1));
  assign pre_tick = (count == CW'(DIV - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_ctrl
//   Read-side controller for the 8-bit UART FIFO. Pops one byte at a time from
//   the FIFO read port and serialises it onto txd: start bit, 8 data bits LSB
//   first, optional even parity, STOP_BITS stop bits. Back-to-back frames start
//   with no idle bit when more data is waiting and tx_en is high.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> an even-parity bit (XOR of the data bits) follows the data
//     undefined -> data goes straight to the stop bit(s)
//
//   Ports:
//     clk        in   system clock (also the FIFO read clock)
//     rst_n      in   asynchronous active-low reset
//     tx_en      in   allow new frames to start (current frame always finishes)
//     fifo_empty in   FIFO empty flag
//     fifo_do    in   FIFO read data, valid the cycle after fifo_re
//     fifo_re    out  FIFO read enable, single-cycle pulse per frame
//     txd        out  UART serial output, idle high
//     busy       out  high from POP until the last stop bit ends
//     byte_done  out  one-cycle pulse on the last clock of each frame
//
//   All outputs are registered: each is loaded from the next-state decode so
//   that it lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 24000000,
  parameter int BAUD      = 115200,
  parameter int DIV       = CLK_HZ / BAUD,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_do,
  output logic       fifo_re,
  output logic       txd,
  output logic       busy,
  output logic       byte_done
);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       tick;
  logic       pre_tick;
  logic       run;
  logic       clr;
  logic       start_ok;
  logic       last_stop;
  logic       txd_nxt;
`ifdef UART_TX_PARITY_EN
  logic       par;
`endif

  // Request sampling happens only where the FSM consults these: IDLE and the
  // final stop clock.
  assign start_ok  = tx_en & ~fifo_empty;
  assign last_stop = (state == STOP) && (stop_idx == 1'(STOP_BITS - 1));

  // The counter only runs while a bit is on the line; LOAD zeroes it so the
  // start bit gets a full DIV clocks.
  assign run = (state == START) || (state == DATA) ||
               (state == PARITY) || (state == STOP);
  assign clr = (state == LOAD);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .run      (run),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = POP;
      POP:   state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: if (tick) state_nxt = DATA;
      DATA: begin
        if (tick && (bit_idx == 3'(UART_DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_nxt = STOP;
`endif
      STOP: begin
        // Chain straight into the next pop when more data is waiting.
        if (tick && last_stop) state_nxt = start_ok ? POP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level for the state being entered. On a data-bit boundary the shift
  // register has not shifted yet, so the next bit is shreg[1].
  always_comb begin
    txd_nxt = UART_IDLE_LEVEL;
    case (state_nxt)
      START:  txd_nxt = 1'b0;
      DATA:   txd_nxt = ((state == DATA) && tick) ? shreg[1] : shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_nxt = par;
`endif
      default: txd_nxt = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      txd       <= UART_IDLE_LEVEL;
      fifo_re   <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      txd       <= txd_nxt;
      fifo_re   <= (state_nxt == POP);
      busy      <= (state_nxt != IDLE);
      // pre_tick is one clock early, so the registered pulse lands on the
      // final clock of the last stop bit.
      byte_done <= last_stop && pre_tick;
      case (state)
        LOAD: begin
          shreg    <= fifo_do;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
          par      <= ^fifo_do;
`endif
        end
        DATA: begin
          if (tick) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (tick) stop_idx <= stop_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
